// File: rtl/naive_bus_fifo_slave_if.sv
// naive_bus: split read/write request-grant bus between a master and a register slave
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [3:0]  rd_be;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  modport master (
    output rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );
  modport slave (
    input  rd_req, rd_addr, rd_be, wr_req, wr_addr, wr_be, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_fifo_slave.sv
// naive_bus_fifo_slave: memory-mapped FIFO with status, control, threshold and level interrupt
module naive_bus_fifo_slave #(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  naive_bus.slave  bus_slave,
  output logic     irq
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] count, count_nxt;
  logic ovf, udf;
  logic [7:0] thresh;
  logic [31:0] rdata, rd_val, status, wmask;
  logic [1:0] rsel, wsel;
  logic empty, full, wr_gnt, pop, push, rd_under, wr_over, ctrl_wr, flush, clr, thresh_wr;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus_slave.rd_be, bus_slave.rd_addr[31:4], bus_slave.rd_addr[1:0],
                       bus_slave.wr_addr[31:4], bus_slave.wr_addr[1:0]};
  assign rsel = bus_slave.rd_addr[3:2];
  assign wsel = bus_slave.wr_addr[3:2];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign wr_gnt = bus_slave.wr_req & ~bus_slave.rd_req;
  assign bus_slave.rd_gnt = bus_slave.rd_req;
  assign bus_slave.wr_gnt = wr_gnt;
  assign bus_slave.rd_data = rdata;
  assign wmask = {{8{bus_slave.wr_be[3]}}, {8{bus_slave.wr_be[2]}},
                  {8{bus_slave.wr_be[1]}}, {8{bus_slave.wr_be[0]}}};
  assign status = {8'h0, 8'(count), 12'h0, udf, ovf, full, empty};
  // Decode granted accesses into FIFO and register actions
  always_comb begin
    pop = bus_slave.rd_req && rsel == 2'd0 && !empty;
    rd_under = bus_slave.rd_req && rsel == 2'd0 && empty;
    push = wr_gnt && wsel == 2'd0 && !full;
    wr_over = wr_gnt && wsel == 2'd0 && full;
    ctrl_wr = wr_gnt && wsel == 2'd2 && bus_slave.wr_be[0];
    flush = ctrl_wr && bus_slave.wr_data[0];
    clr = ctrl_wr && bus_slave.wr_data[1];
    thresh_wr = wr_gnt && wsel == 2'd3 && bus_slave.wr_be[0];
    count_nxt = flush ? '0 : push ? count + 1'b1 : pop ? count - 1'b1 : count;
    rd_val = rsel == 2'd0 ? (empty ? 32'h0 : mem[rp]) :
             rsel == 2'd1 ? status :
             rsel == 2'd3 ? {24'h0, thresh} : 32'h0;
  end
  // FIFO storage; contents are don't-care after reset or flush
  always_ff @(posedge clk)
    if (push) mem[wp] <= bus_slave.wr_data & wmask;
  // Pointers, count, sticky flags, threshold, read data and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      thresh <= 8'h0;
      rdata <= 32'h0;
      irq <= 1'b0;
    end else begin
      rp <= flush ? '0 : pop ? rp + 1'b1 : rp;
      wp <= flush ? '0 : push ? wp + 1'b1 : wp;
      count <= count_nxt;
      ovf <= clr ? 1'b0 : ovf | wr_over;
      udf <= clr ? 1'b0 : udf | rd_under;
      thresh <= thresh_wr ? bus_slave.wr_data[7:0] : thresh;
      rdata <= bus_slave.rd_req ? rd_val : rdata;
      irq <= thresh != 8'h0 && 8'(count) >= thresh;
    end
  end
endmodule

// File: tb/tb_naive_bus_fifo_slave.sv
// tb_naive_bus_fifo_slave: scoreboard bench driving the FIFO slave against a queue model
module tb_naive_bus_fifo_slave;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] model [$];
  logic [31:0] sb [$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;
  logic [7:0] m_thr = 8'h0;
  logic [31:0] last_exp = 32'h0;
  logic [31:0] e;
  naive_bus bus ();
  naive_bus_fifo_slave #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus_slave(bus),
    .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ra(input int r);
    return {28'($urandom()), 2'(r), 2'($urandom())};
  endfunction
  function automatic logic [31:0] m_status();
    return {8'h0, 8'(model.size()), 12'h0, m_udf, m_ovf, model.size() == DEPTH, model.size() == 0};
  endfunction
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.wr_req = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be = be;
    #1 check("wr_gnt", 32'(bus.wr_gnt), 32'd1);
    case (a[3:2])
      2'd0: if (model.size() == DEPTH) m_ovf = 1'b1;
            else model.push_back(d & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
      2'd2: if (be[0]) begin
              if (d[0]) model.delete();
              if (d[1]) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
              end
            end
      2'd3: if (be[0]) m_thr = d[7:0];
      default: ;
    endcase
    @(negedge clk);
    bus.wr_req = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a);
    logic [31:0] x;
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_addr = a;
    bus.rd_be = 4'($urandom());
    #1 check("rd_gnt", 32'(bus.rd_gnt), 32'd1);
    case (a[3:2])
      2'd0: if (model.size() == 0) begin
              x = 32'h0;
              m_udf = 1'b1;
            end else x = model.pop_front();
      2'd1: x = m_status();
      2'd3: x = {24'h0, m_thr};
      default: x = 32'h0;
    endcase
    sb.push_back(x);
    @(negedge clk);
    bus.rd_req = 1'b0;
    last_exp = sb.pop_front();
    check("rd_data", bus.rd_data, last_exp);
  endtask
  initial begin
    bus.rd_req = 1'b0;
    bus.rd_addr = 32'h0;
    bus.rd_be = 4'h0;
    bus.wr_req = 1'b0;
    bus.wr_addr = 32'h0;
    bus.wr_data = 32'h0;
    bus.wr_be = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    #1 check("rst_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    check("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wr(ra(0), 32'h11111111, 4'hf);
    wr(ra(0), 32'h22222222, 4'hf);
    wr(ra(0), 32'h33333333, 4'hf);
    rd(ra(1));
    repeat (3) rd(ra(0));
    rd(ra(1));
    repeat (2) @(negedge clk);
    check("rd_data_hold", bus.rd_data, last_exp);
    for (int i = 0; i < DEPTH; i++) wr(ra(0), $urandom(), 4'hf);
    wr(ra(0), 32'hDEADBEEF, 4'hf);
    rd(ra(1));
    for (int i = 0; i < DEPTH; i++) rd(ra(0));
    rd(ra(0));
    rd(ra(1));
    wr(ra(2), 32'h2, 4'h1);
    rd(ra(1));
    rd(ra(2));
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_addr = ra(1);
    bus.wr_req = 1'b1;
    bus.wr_addr = ra(0);
    bus.wr_data = 32'hAAAA5555;
    bus.wr_be = 4'hf;
    #1 check("rw_rd_gnt", 32'(bus.rd_gnt), 32'd1);
    check("rw_wr_gnt", 32'(bus.wr_gnt), 32'd0);
    e = m_status();
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    check("rw_status", bus.rd_data, e);
    rd(ra(1));
    wr(ra(0), 32'hAAAA5555, 4'hf);
    rd(ra(1));
    rd(ra(0));
    wr(ra(0), 32'h12345678, 4'b0101);
    rd(ra(0));
    wr(ra(3), 32'h2, 4'h1);
    wr(ra(3), 32'h5, 4'b1110);
    rd(ra(3));
    wr(ra(0), 32'h1, 4'hf);
    check("irq_one", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_one_late", 32'(irq), 32'd0);
    wr(ra(0), 32'h2, 4'hf);
    check("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
    wr(ra(2), 32'h1, 4'h1);
    check("irq_flush_lag", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);
    rd(ra(0));
    wr(ra(2), 32'h2, 4'h1);
    for (int i = 0; i < 4; i++) wr(ra(0), $urandom(), 4'hf);
    rd(ra(0));
    rd(ra(0));
    for (int c = 0; c < 3; c++) begin
      while (model.size() < DEPTH) wr(ra(0), $urandom(), 4'hf);
      rd(ra(1));
      while (model.size() > 0) rd(ra(0));
    end
    rd(ra(1));
    for (int i = 0; i < 4; i++) wr(ra(0), $urandom(), 4'hf);
    @(negedge clk);
    check("irq_pre_rst", 32'(irq), 32'd1);
    bus.rd_req = 1'b1;
    bus.rd_addr = ra(0);
    #2 rst = 1'b1;
    #1 check("mid_rst_rd_data", bus.rd_data, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    model.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_thr = 8'h0;
    @(negedge clk);
    bus.rd_req = 1'b0;
    rst = 1'b0;
    rd(ra(1));
    rd(ra(3));
    rd(ra(0));
    rd(ra(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/naive_bus_fifo_slave.md
NAIVE_BUS_FIFO_SLAVE -- requirements
Module: naive_bus_fifo_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of 2, 2..128).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port bus_slave  naive_bus.slave  -  responder end: rd_req/rd_gnt/rd_addr[31:0]/rd_be[3:0]/rd_data[31:0], wr_req/wr_gnt/wr_addr[31:0]/wr_be[3:0]/wr_data[31:0].
REQ-005 SHALL have port irq  output  1  level interrupt, FIFO at/above threshold.

Function
REQ-006 SHALL decode only addr[3:2]; upper bits ignored (decoded upstream). Map: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
REQ-007 SHALL drive rd_gnt = rd_req combinationally, every cycle.
REQ-008 SHALL drive wr_gnt = wr_req & ~rd_req (read priority; ungranted write has no effect).
REQ-009 SHALL register rd_data: value for a granted read appears in the cycle after grant; rd_data holds its value in cycles with no granted read.
REQ-010 SHALL ignore rd_be; reads always return full 32-bit word.
REQ-011 DATA read (granted): rd_data <= head entry, pop (read pointer +1 mod DEPTH, count -1); if empty: rd_data <= 0, no pop, underflow flag set.
REQ-012 DATA write (granted): push (wr_data with bytes where wr_be[i]=0 forced to 0), write pointer +1 mod DEPTH, count +1; if full: data dropped, overflow flag set, no pointer change.
REQ-013 STATUS read: bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bits[23:16] count (zero-extended), others 0; STATUS writes ignored.
REQ-014 CTRL write with wr_be[0]=1: bit0 flush (pointers and count to 0 next edge; stored data need not clear), bit1 clear overflow and underflow; both bits may act in one write. CTRL reads return 0.
REQ-015 THRESH: 8-bit RW in bits[7:0], written only when wr_be[0]=1; reads {24'b0,thresh}.
REQ-016 irq SHALL be registered: irq <= (thresh != 0) & (count >= thresh), evaluated on post-update count, so irq follows count change by one cycle.
REQ-017 Count range 0..DEPTH; full = (count==DEPTH), empty = (count==0); pointers wrap with no gap.
REQ-018 Sticky flags SHALL set on event and clear only via CTRL bit1 or reset; set and clear in same cycle cannot occur (read priority prevents it).
REQ-019 Read of DATA after a flush in prior cycle SHALL see empty (returns 0, underflow set).
REQ-020 Read and write same cycle: read performed, write stalled (wr_gnt=0); master retries.

Reset
REQ-021 While rst=1: pointers, count 0; flags 0; thresh 0; rd_data 32'h0; irq 0; rd_gnt/wr_gnt remain combinational per REQ-007/008.
REQ-022 rst SHALL act asynchronously mid-transaction; a read granted in the cycle rst asserts returns 0, FIFO contents discarded.

Verification
REQ-023 Push 0x11111111, 0x22222222, 0x33333333 to DATA; read STATUS -> 0x00030000; three DATA reads -> 0x11111111, 0x22222222, 0x33333333 one cycle after each grant; STATUS -> 0x00000001.
REQ-024 Fill 16 entries then write 0xDEADBEEF -> STATUS 0x00100006; drain 16 words, no 0xDEADBEEF; 17th DATA read -> 0 and STATUS bit3 set; CTRL write 0x2 -> STATUS 0x00000001.
REQ-025 rd_req and wr_req (DATA, 0xAAAA5555) same cycle -> rd_gnt=1, wr_gnt=0, count unchanged; next cycle write alone -> wr_gnt=1, count 1.
REQ-026 Write DATA 0x12345678 with wr_be=4'b0101 -> popped value 0x00340078.
REQ-027 THRESH=2: push 1 -> irq 0; push 2nd -> irq 1 one cycle after count reaches 2; CTRL 0x1 (flush) -> count 0, irq 0 following cycle.
REQ-028 Push 4 words, wrap pointers through 3 full fill/drain cycles with DEPTH=16 -> data order preserved; assert rst mid-stream -> immediately count 0, rd_data 0, irq 0.
